// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier for the multicycle datapath.
// One Booth step per clock; the start/stop handshake matches the divider's.
//
// state  | meaning
// IDLE   | waiting for w_MultStart; HI/LO hold the last product
// CALC   | one Booth add/shift step per edge, WIDTH steps in total
// DONE   | w_MultStop high for one cycle; a new start is accepted here too
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             w_MultStart,
  input  logic [WIDTH-1:0] w_A,
  input  logic [WIDTH-1:0] w_B,
  output logic             w_MultBusy,
  output logic             w_MultStop,
  output logic [WIDTH-1:0] w_MULTHI,
  output logic [WIDTH-1:0] w_MULTLO
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_step;
  logic             accept;

  // ACC is one bit wider than the operands so subtracting M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    acc_sum = acc;
    case ({q[0], q_1})
      2'b01:   acc_sum = acc + m;
      2'b10:   acc_sum = acc - m;
      default: acc_sum = acc;
    endcase
    acc_nxt   = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    q_nxt     = {acc_sum[0], q[WIDTH-1:1]};
    last_step = (cnt == CNT_W'(WIDTH - 1));
    accept    = w_MultStart && ((state == S_IDLE) || (state == S_DONE));
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      m          <= '0;
      acc        <= '0;
      q          <= '0;
      q_1        <= 1'b0;
      cnt        <= '0;
      w_MultBusy <= 1'b0;
      w_MultStop <= 1'b0;
      w_MULTHI   <= '0;
      w_MULTLO   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          w_MultStop <= 1'b0;
          if (accept) begin
            m          <= {w_A[WIDTH-1], w_A};
            q          <= w_B;
            q_1        <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            w_MultBusy <= 1'b1;
            state      <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          q_1 <= q[0];
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            // ACC[WIDTH] is only sign extension of the product by now.
            w_MULTHI   <= acc_nxt[WIDTH-1:0];
            w_MULTLO   <= q_nxt;
            w_MultStop <= 1'b1;
            w_MultBusy <= 1'b0;
            state      <= S_DONE;
          end
        end
        default: begin
          state      <= S_IDLE;
          w_MultBusy <= 1'b0;
          w_MultStop <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: the driver queues expected products and
// completion cycles, a negedge monitor checks them whenever w_MultStop fires.
module tb_booth_mult;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         w_MultStart = 1'b0;
  logic [W-1:0] w_A = '0;
  logic [W-1:0] w_B = '0;
  logic         w_MultBusy;
  logic         w_MultStop;
  logic [W-1:0] w_MULTHI;
  logic [W-1:0] w_MULTLO;

  booth_mult #(.WIDTH(W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .w_MultStart (w_MultStart),
    .w_A         (w_A),
    .w_B         (w_B),
    .w_MultBusy  (w_MultBusy),
    .w_MultStop  (w_MultStop),
    .w_MULTHI    (w_MULTHI),
    .w_MULTLO    (w_MULTLO)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_run = 0;
  bit   prev_stop = 1'b0;

  always @(posedge Clock) cyc++;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes one scoreboard entry per completion pulse.
  always @(negedge Clock) begin
    if (!Reset) begin
      busy_run  = 0;
      prev_stop = 1'b0;
    end else begin
      if (w_MultBusy) busy_run++;
      if (w_MultStop) begin
        check("stop_width", {63'd0, prev_stop}, 64'd0);
        check("busy_low_in_done", {63'd0, w_MultBusy}, 64'd0);
        check("busy_length", 64'(busy_run), 64'(W));
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_stop: got stop with empty scoreboard, expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", {w_MULTHI, w_MULTLO}, e.prod);
          check("latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (!w_MultBusy) busy_run = 0;
      prev_stop = w_MultStop;
    end
  end

  // Called at a negedge; Start is sampled at the following posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] prod);
    exp_t e;
    e.prod = prod;
    e.cyc  = cyc + 1 + W;
    sb.push_back(e);
    w_MultStart = 1'b1;
    w_A = a;
    w_B = b;
    @(negedge Clock);
    w_MultStart = 1'b0;
    w_A = $urandom;
    w_B = $urandom;
  endtask

  task automatic wait_stop();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      if (w_MultStop) seen = 1'b1;
      else @(negedge Clock);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL stop_timeout: got no stop within %0d cycles, expected stop (t=%0t)", 4 * W, $time);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] prod);
    start_op(a, b, prod);
    wait_stop();
    @(negedge Clock);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'd7,        32'd3,        32'h00000000, 32'h00000015};
    vecs[1] = '{32'hFFFFFFFB, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4] = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
    vecs[5] = '{32'd0,        32'd0,        32'h00000000, 32'h00000000};
    vecs[6] = '{32'd0,        32'd12345,    32'h00000000, 32'h00000000};
    vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[8] = '{32'd1,        32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[9] = '{32'd12,       32'hFFFFFFF4, 32'hFFFFFFFF, 32'hFFFFFF70};

    // Reset state
    #1;
    check("reset_busy", {63'd0, w_MultBusy}, 64'd0);
    check("reset_stop", {63'd0, w_MultStop}, 64'd0);
    check("reset_hilo", {w_MULTHI, w_MULTLO}, 64'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

    // Product holds after completion and is not cleared by a new Start
    repeat (5) @(negedge Clock);
    check("hold_hilo", {w_MULTHI, w_MULTLO}, {vecs[9].hi, vecs[9].lo});
    start_op(32'd100, 32'd5, 64'd500);
    check("start_keeps_hilo", {w_MULTHI, w_MULTLO}, {vecs[9].hi, vecs[9].lo});
    check("busy_after_start", {63'd0, w_MultBusy}, 64'd1);
    wait_stop();
    @(negedge Clock);

    // Start during CALC is ignored; Start in DONE launches back-to-back op
    start_op(32'd6, 32'd7, 64'd42);
    repeat (9) @(negedge Clock);
    w_MultStart = 1'b1;
    w_A = 32'd1000;
    w_B = 32'd1000;
    repeat (3) @(negedge Clock);
    w_MultStart = 1'b0;
    wait_stop();
    start_op(32'hFFFFFFFE, 32'd9, 64'hFFFFFFFF_FFFFFFEE);
    wait_stop();
    @(negedge Clock);

    // Reset mid-CALC aborts with no Stop pulse
    start_op(32'h1234, 32'h5678, 64'h0);
    repeat (9) @(negedge Clock);
    Reset = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", {63'd0, w_MultBusy}, 64'd0);
    check("abort_stop", {63'd0, w_MultStop}, 64'd0);
    check("abort_hilo", {w_MULTHI, w_MULTLO}, 64'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    begin
      int stops = 0;
      for (int i = 0; i < W + 5; i++) begin
        @(negedge Clock);
        if (w_MultStop) stops++;
      end
      check("no_stop_after_abort", 64'(stops), 64'd0);
    end
    run_op(32'd12, 32'hFFFFFFF4, 64'hFFFFFFFF_FFFFFF70);

    // A short run of random signed pairs against the language's multiply
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] a, b;
      longint p;
      a = $urandom;
      b = $urandom;
      p = longint'($signed(a)) * longint'($signed(b));
      run_op(a, b, 64'(p));
    end

    repeat (3) @(negedge Clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
